// File: rtl/risc_pkg.sv
// Shared opcode values, controller state encoding and opcode helper for the RISC sequencer.
package risc_pkg;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  // Phases 0..7 occupy the low three bits; HALTED sits outside the cycle.
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_ctrl.sv
// Eight-phase instruction sequencer with mem_rdy wait/timeout and halt/resume.
// Optional macro RISC_CTRL_SINGLE_STEP_EN adds a step input that gates each instruction.
module risc_ctrl
  import risc_pkg::*;
#(
  parameter int OPC_W    = 3,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_rdy,
  input  logic             run,
`ifdef RISC_CTRL_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             fch,
  output logic             rd,
  output logic             wr,
  output logic             ld_ir,
  output logic             ld_ac,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             data_e,
  output logic             halt,
  output logic             fault,
  output logic [2:0]       phase
);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              alu;
  logic              waiting;
  logic              go;

  assign alu     = is_aluop(opcode);
  assign waiting = (state == INST_FETCH) || ((state == OP_FETCH) && alu);

`ifdef RISC_CTRL_SINGLE_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  // A held fetch phase counts cycles; running out of budget parks the controller with a sticky fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INST_ADDR;
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else if (waiting && !mem_rdy) begin
      if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
        state    <= HALTED;
        wait_cnt <= '0;
        fault    <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
      case (state)
        INST_ADDR:  if (go) state <= INST_FETCH;
        INST_FETCH: state <= INST_LOAD;
        INST_LOAD:  state <= IDLE;
        IDLE:       state <= OP_ADDR;
        OP_ADDR:    state <= (opcode == HLT) ? HALTED : OP_FETCH;
        OP_FETCH:   state <= ALU_OP;
        ALU_OP:     state <= STORE;
        STORE:      state <= INST_ADDR;
        HALTED:     if (run) state <= INST_ADDR;
        default:    state <= INST_ADDR;
      endcase
    end
  end

  always_comb begin
    fch    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    case (state)
      INST_ADDR:  fch = 1'b1;
      INST_FETCH: begin fch = 1'b1; rd = 1'b1; end
      INST_LOAD,
      IDLE:       begin fch = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
      OP_ADDR:    inc_pc = 1'b1;
      OP_FETCH:   rd = alu;
      ALU_OP: begin
        rd     = alu;
        inc_pc = (opcode == SKZ) && zero;
        ld_pc  = (opcode == JMP);
        data_e = (opcode == STO);
      end
      STORE: begin
        rd     = alu;
        ld_ac  = alu;
        ld_pc  = (opcode == JMP);
        inc_pc = (opcode == JMP);
        wr     = (opcode == STO);
        data_e = (opcode == STO);
      end
      HALTED:     begin fch = 1'b1; halt = 1'b1; end
      default:    fch = 1'b1;
    endcase
  end

  assign phase = (state == HALTED) ? 3'd0 : state[2:0];

endmodule

// File: tb/tb_risc_ctrl.sv
// Randomized self-checking bench for risc_ctrl against a phase-table reference model.
module tb_risc_ctrl;

  localparam int MAX_WAIT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       mem_rdy = 1'b1;
  logic       run = 1'b0;
  logic       fch, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, fault;
  logic [2:0] phase;

  int total = 0;
  int bad = 0;

  // Reference model: plain phase number, halted flag, held-cycle count, sticky fault.
  int m_phase = 0;
  bit m_halted = 0;
  int m_wait = 0;
  bit m_fault = 0;

  always #5 clk = ~clk;

  risc_ctrl #(.OPC_W(3), .MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_rdy(mem_rdy), .run(run),
`ifdef RISC_CTRL_SINGLE_STEP_EN
    .step(1'b1),
`endif
    .fch(fch), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc),
    .inc_pc(inc_pc), .data_e(data_e), .halt(halt), .fault(fault), .phase(phase)
  );

  task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h (model phase=%0d halted=%0d op=%0d)",
               tag, got, want, m_phase, m_halted, opcode);
    end
  endtask

  // Expected strobes {fch,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,halt} from the phase table.
  function automatic logic [8:0] expected_strobes(int p, bit h, int op, bit z);
    bit alu = (op >= 2 && op <= 5);
    if (h) return 9'b1_0000_0001;
    return {p < 4,
            (p >= 1 && p <= 3) || (p >= 5 && alu),
            p == 7 && op == 6,
            p == 2 || p == 3,
            p == 7 && alu,
            (p == 6 || p == 7) && op == 7,
            p == 4 || (p == 6 && op == 1 && z) || (p == 7 && op == 7),
            (p == 6 || p == 7) && op == 6,
            1'b0};
  endfunction

  task automatic compare_all();
    check_output("strobes", {7'd0, fch, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt},
                 {7'd0, expected_strobes(m_phase, m_halted, int'(opcode), zero)});
    check_output("phase", {13'd0, phase}, m_halted ? 16'd0 : 16'(m_phase));
    check_output("fault", {15'd0, fault}, {15'd0, m_fault});
  endtask

  task automatic model_step();
    int op = int'(opcode);
    bit alu = (op >= 2 && op <= 5);
    if (m_halted) begin
      if (run) begin m_halted = 0; m_phase = 0; end
    end else if ((m_phase == 1 || (m_phase == 5 && alu)) && !mem_rdy) begin
      m_wait++;
      if (m_wait == MAX_WAIT) begin m_halted = 1; m_fault = 1; m_wait = 0; end
    end else begin
      m_wait = 0;
      if (m_phase == 4 && op == 0) m_halted = 1;
      else m_phase = (m_phase + 1) % 8;
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_halted = 0; m_wait = 0; m_fault = 0;
  endtask

  // One clock: drive inputs, check on the falling edge, advance the model on the rising edge.
  task automatic apply_stimulus(input logic [2:0] op, input logic z, input logic rdy, input logic r);
    opcode = op; zero = z; mem_rdy = rdy; run = r;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    int guard;
    #12;
    compare_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) apply_stimulus(3'd2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) apply_stimulus(3'd6, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) apply_stimulus(3'd1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) apply_stimulus(3'd1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) apply_stimulus(3'd7, 1'b0, 1'b1, 1'b0);

    // Short fetch stall then recovery.
    apply_stimulus(3'd2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(3'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) apply_stimulus(3'd2, 1'b0, 1'b1, 1'b0);
    check_output("no_fault_after_stall", {15'd0, fault}, 16'd0);

    // Full timeout in INST_FETCH.
    apply_stimulus(3'd2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < MAX_WAIT; i++) apply_stimulus(3'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(3'd2, 1'b0, 1'b0, 1'b0);
    check_output("timeout_halt", {15'd0, halt}, 16'd1);
    apply_stimulus(3'd2, 1'b0, 1'b1, 1'b1);

    // HLT instruction, then resume.
    for (int i = 0; i < 8; i++) apply_stimulus(3'd0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(3'd0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 600; i++)
      apply_stimulus(3'($urandom_range(7)), 1'($urandom_range(1)),
                     $urandom_range(9) < 8, $urandom_range(9) < 2);

    // Asynchronous reset in the middle of a store.
    guard = 0;
    while (!(m_phase == 7 && !m_halted) && guard < 100) begin
      apply_stimulus(3'd6, 1'b0, 1'b1, m_halted);
      guard++;
    end
    check_output("reach_store", 16'(m_phase == 7 && !m_halted), 16'd1);
    #2;
    check_output("wr_before_reset", {15'd0, wr}, 16'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("reset_fch_wr", {14'd0, fch, wr}, 16'b10);
    compare_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) apply_stimulus(3'd5, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
